// File: rtl/ir_nec_pkg.sv
// Shared NEC decoder definitions: FSM state type, timing windows in microseconds and
// helpers that turn them into clock counts for a given CLK_HZ.
package ir_nec_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK,
    RPT_STOP
  } nec_state_t;

  localparam int unsigned LeadMarkLoUs  = 8000;
  localparam int unsigned LeadMarkHiUs  = 10000;
  localparam int unsigned LeadSpaceLoUs = 4000;
  localparam int unsigned LeadSpaceHiUs = 5000;
  localparam int unsigned RptSpaceLoUs  = 2000;
  localparam int unsigned RptSpaceHiUs  = 2500;
  localparam int unsigned BitMarkLoUs   = 400;
  localparam int unsigned BitMarkHiUs   = 700;
  localparam int unsigned Data0LoUs     = 400;
  localparam int unsigned Data0HiUs     = 800;
  localparam int unsigned Data1LoUs     = 1400;
  localparam int unsigned Data1HiUs     = 1900;
  localparam int unsigned MaxIntervalUs = 10000;

  function automatic int unsigned us_to_clk(input int unsigned clk_hz, input int unsigned us);
    longint unsigned prod;
    prod = (64'(clk_hz) * 64'(us)) / 64'd1000000;
    return prod[31:0];
  endfunction

  // One spare bit above the longest window keeps the saturated value clearly out of range.
  function automatic int unsigned cnt_width(input int unsigned clk_hz);
    return $clog2(us_to_clk(clk_hz, MaxIntervalUs)) + 1;
  endfunction

  function automatic logic in_window(input logic [31:0] len, input int unsigned lo,
                                     input int unsigned hi);
    return (len >= lo) && (len <= hi);
  endfunction

  function automatic logic frame_ok(input logic [31:0] f, input logic chk_addr);
    return (f[31:24] == ~f[23:16]) && (!chk_addr || (f[15:8] == ~f[7:0]));
  endfunction

endpackage

// File: rtl/ir_sync_edge.sv
// Two-flop synchronizer for the raw IR line plus one history flop for edge detection.
module ir_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_rxd,
  output logic level,
  output logic rise,
  output logic fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Flops reset to the idle-high line level so release never fakes an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_rxd;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign level = r_sync;
  assign rise  = r_sync & ~r_prev;
  assign fall  = ~r_sync & r_prev;

endmodule

// File: rtl/ir_nec_decoder.sv
// NEC IR frame decoder: times marks and spaces on the synchronized line, assembles 32 bits
// LSB first, validates complements and reports frames, repeat codes and errors as pulses.
module ir_nec_decoder #(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter bit          CHECK_ADDR = 1'b0
) (
  input  logic        clk,
  input  logic        Rkey,
  input  logic        IRDA_RXD,
  output logic [31:0] frame,
  output logic [7:0]  cmd,
  output logic        valid,
  output logic        rpt,
  output logic        err
);

  import ir_nec_pkg::*;

  localparam int unsigned CntW        = cnt_width(CLK_HZ);
  localparam int unsigned LeadMarkLo  = us_to_clk(CLK_HZ, LeadMarkLoUs);
  localparam int unsigned LeadMarkHi  = us_to_clk(CLK_HZ, LeadMarkHiUs);
  localparam int unsigned LeadSpaceLo = us_to_clk(CLK_HZ, LeadSpaceLoUs);
  localparam int unsigned LeadSpaceHi = us_to_clk(CLK_HZ, LeadSpaceHiUs);
  localparam int unsigned RptSpaceLo  = us_to_clk(CLK_HZ, RptSpaceLoUs);
  localparam int unsigned RptSpaceHi  = us_to_clk(CLK_HZ, RptSpaceHiUs);
  localparam int unsigned BitMarkLo   = us_to_clk(CLK_HZ, BitMarkLoUs);
  localparam int unsigned BitMarkHi   = us_to_clk(CLK_HZ, BitMarkHiUs);
  localparam int unsigned Data0Lo     = us_to_clk(CLK_HZ, Data0LoUs);
  localparam int unsigned Data0Hi     = us_to_clk(CLK_HZ, Data0HiUs);
  localparam int unsigned Data1Lo     = us_to_clk(CLK_HZ, Data1LoUs);
  localparam int unsigned Data1Hi     = us_to_clk(CLK_HZ, Data1HiUs);

  logic w_unused_level;
  logic w_rise;
  logic w_fall;

  ir_sync_edge u_sync_edge (
    .clk   (clk),
    .rst_n (Rkey),
    .i_rxd (IRDA_RXD),
    .level (w_unused_level),
    .rise  (w_rise),
    .fall  (w_fall)
  );

  nec_state_t      r_state;
  logic [CntW-1:0] r_cnt;
  logic [5:0]      r_bits;
  logic [31:0]     r_shift;
  logic [31:0]     r_frame;
  logic [7:0]      r_cmd;
  logic            r_valid;
  logic            r_rpt;
  logic            r_err;
  logic            r_rpt_en;

  // Interval length including the cycle of the closing edge, so a line held N clk reads N.
  logic [31:0] w_len;
  logic        w_is0;
  logic        w_is1;
  logic        w_mark_ok;

  assign w_len     = 32'(r_cnt) + 32'd1;
  assign w_is0     = in_window(w_len, Data0Lo, Data0Hi);
  assign w_is1     = in_window(w_len, Data1Lo, Data1Hi);
  assign w_mark_ok = in_window(w_len, BitMarkLo, BitMarkHi);

  always_ff @(posedge clk or negedge Rkey) begin
    if (!Rkey) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_bits   <= '0;
      r_shift  <= '0;
      r_frame  <= '0;
      r_cmd    <= '0;
      r_valid  <= 1'b0;
      r_rpt    <= 1'b0;
      r_err    <= 1'b0;
      r_rpt_en <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_rpt   <= 1'b0;
      r_err   <= 1'b0;

      if (w_rise || w_fall) begin
        r_cnt <= '0;
      end else if (r_cnt != {CntW{1'b1}}) begin
        r_cnt <= r_cnt + CntW'(1);
      end

      unique case (r_state)
        IDLE: begin
          if (w_fall) r_state <= LEAD_MARK;
        end

        LEAD_MARK: begin
          if (w_rise) begin
            if (in_window(w_len, LeadMarkLo, LeadMarkHi)) begin
              r_state <= LEAD_SPACE;
            end else begin
              r_state <= IDLE;
              r_err   <= 1'b1;
            end
          end else if (w_len > LeadMarkHi) begin
            r_state <= IDLE;
            r_err   <= 1'b1;
          end
        end

        LEAD_SPACE: begin
          if (w_fall) begin
            if (in_window(w_len, LeadSpaceLo, LeadSpaceHi)) begin
              r_state <= BIT_MARK;
              r_bits  <= '0;
            end else if (in_window(w_len, RptSpaceLo, RptSpaceHi)) begin
              r_state <= RPT_STOP;
            end else begin
              r_state <= IDLE;
              r_err   <= 1'b1;
            end
          end else if (w_len > LeadSpaceHi) begin
            r_state <= IDLE;
            r_err   <= 1'b1;
          end
        end

        BIT_MARK: begin
          if (w_rise) begin
            if (w_mark_ok) begin
              r_state <= BIT_SPACE;
            end else begin
              r_state <= IDLE;
              r_err   <= 1'b1;
            end
          end else if (w_len > BitMarkHi) begin
            r_state <= IDLE;
            r_err   <= 1'b1;
          end
        end

        BIT_SPACE: begin
          if (w_fall) begin
            if (w_is0 || w_is1) begin
              r_shift <= {w_is1, r_shift[31:1]};
              r_bits  <= r_bits + 6'd1;
              r_state <= (r_bits == 6'd31) ? STOP_MARK : BIT_MARK;
            end else begin
              r_state <= IDLE;
              r_err   <= 1'b1;
            end
          end else if (w_len > Data1Hi) begin
            r_state <= IDLE;
            r_err   <= 1'b1;
          end
        end

        STOP_MARK: begin
          if (w_rise) begin
            r_state <= IDLE;
            if (w_mark_ok && frame_ok(r_shift, CHECK_ADDR)) begin
              r_frame  <= r_shift;
              r_cmd    <= r_shift[23:16];
              r_valid  <= 1'b1;
              r_rpt_en <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
          end else if (w_len > BitMarkHi) begin
            r_state <= IDLE;
            r_err   <= 1'b1;
          end
        end

        RPT_STOP: begin
          if (w_rise) begin
            r_state <= IDLE;
            // A repeat with no frame to repeat is dropped silently, not flagged.
            if (w_mark_ok) begin
              r_rpt <= r_rpt_en;
            end else begin
              r_err <= 1'b1;
            end
          end else if (w_len > BitMarkHi) begin
            r_state <= IDLE;
            r_err   <= 1'b1;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign frame = r_frame;
  assign cmd   = r_cmd;
  assign valid = r_valid;
  assign rpt   = r_rpt;
  assign err   = r_err;

endmodule

// File: tb/tb_ir_nec_decoder.sv
// Directed bench for ir_nec_decoder at CLK_HZ = 50 kHz, where 1 ms = 50 clk and every
// timing window is the 50 MHz figure divided by 1000.
module tb_ir_nec_decoder;

  localparam int unsigned ClkHz   = 50000;
  localparam int          IdleGap = 100;

  logic        clk;
  logic        Rkey;
  logic        IRDA_RXD;
  logic [31:0] frame;
  logic [7:0]  cmd;
  logic        valid;
  logic        rpt;
  logic        err;

  ir_nec_decoder #(
    .CLK_HZ     (ClkHz),
    .CHECK_ADDR (1'b1)
  ) dut (
    .clk      (clk),
    .Rkey     (Rkey),
    .IRDA_RXD (IRDA_RXD),
    .frame    (frame),
    .cmd      (cmd),
    .valid    (valid),
    .rpt      (rpt),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int c_valid   = 0;
  int c_rpt     = 0;
  int c_err     = 0;
  int c_overlap = 0;
  int s_valid;
  int s_rpt;
  int s_err;

  always @(negedge clk) begin
    if (valid) c_valid++;
    if (rpt)   c_rpt++;
    if (err)   c_err++;
    if ((int'(valid) + int'(rpt) + int'(err)) > 1) c_overlap++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    s_valid = c_valid;
    s_rpt   = c_rpt;
    s_err   = c_err;
  endtask

  task automatic check_pulses(input string tag, input int ev, input int er, input int ee);
    check_eq({tag, ".valid"}, 32'(c_valid - s_valid), 32'(ev));
    check_eq({tag, ".rpt"},   32'(c_rpt - s_rpt),     32'(er));
    check_eq({tag, ".err"},   32'(c_err - s_err),     32'(ee));
  endtask

  task automatic hold(input logic v, input int n);
    IRDA_RXD = v;
    repeat (n) @(negedge clk);
  endtask

  // Full frame; bit mod_idx gets a space of mod_sp clk, and with cut the frame stops there.
  task automatic send_frame(input logic [31:0] data, input int mod_idx, input int mod_sp,
                            input bit cut);
    hold(1'b0, 450);
    hold(1'b1, 225);
    for (int i = 0; i < 32; i++) begin
      int sp;
      hold(1'b0, 28);
      sp = data[i] ? 84 : 28;
      if (i == mod_idx) sp = mod_sp;
      hold(1'b1, sp);
      if (cut && (i == mod_idx)) begin
        hold(1'b0, 28);
        hold(1'b1, IdleGap);
        return;
      end
    end
    hold(1'b0, 28);
    hold(1'b1, IdleGap);
  endtask

  task automatic send_repeat();
    hold(1'b0, 450);
    hold(1'b1, 112);
    hold(1'b0, 28);
    hold(1'b1, IdleGap);
  endtask

  initial begin
    logic [31:0] d_a;
    logic [31:0] d_b;
    d_a = 32'hBA45FF00;
    d_b = 32'hED12FB04;

    IRDA_RXD = 1'b1;
    Rkey     = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("rst.frame", frame, 32'h0);
    check_eq("rst.cmd",   {24'h0, cmd}, 32'h0);
    check_eq("rst.pulses", {29'h0, valid, rpt, err}, 32'h0);
    Rkey = 1'b1;
    hold(1'b1, 20);

    snap();
    send_repeat();
    check_pulses("rpt_after_reset", 0, 0, 0);

    snap();
    send_frame(d_a, -1, 0, 1'b0);
    check_pulses("frame_45", 1, 0, 0);
    check_eq("frame_45.frame", frame, 32'hBA45FF00);
    check_eq("frame_45.cmd", {24'h0, cmd}, 32'h45);

    snap();
    send_repeat();
    check_pulses("repeat", 0, 1, 0);
    check_eq("repeat.frame", frame, 32'hBA45FF00);

    snap();
    send_frame(32'hBB45FF00, -1, 0, 1'b0);
    check_pulses("bad_cpl", 0, 0, 1);
    check_eq("bad_cpl.frame", frame, 32'hBA45FF00);
    check_eq("bad_cpl.cmd", {24'h0, cmd}, 32'h45);

    snap();
    send_frame(d_b, -1, 0, 1'b0);
    check_pulses("frame_12", 1, 0, 0);
    check_eq("frame_12.frame", frame, 32'hED12FB04);
    check_eq("frame_12.cmd", {24'h0, cmd}, 32'h12);

    snap();
    hold(1'b0, 350);
    hold(1'b1, IdleGap);
    check_pulses("short_lead", 0, 0, 1);
    snap();
    send_frame(d_a, -1, 0, 1'b0);
    check_pulses("after_short", 1, 0, 0);
    check_eq("after_short.frame", frame, 32'hBA45FF00);

    snap();
    hold(1'b0, 600);
    hold(1'b1, IdleGap);
    check_pulses("stuck_low", 0, 0, 1);
    snap();
    send_frame(d_b, -1, 0, 1'b0);
    check_pulses("after_stuck", 1, 0, 0);
    check_eq("after_stuck.frame", frame, 32'hED12FB04);

    // Reset lands in the space after bit 16 while the line is high.
    snap();
    hold(1'b0, 450);
    hold(1'b1, 225);
    for (int i = 0; i < 15; i++) begin
      hold(1'b0, 28);
      hold(1'b1, d_a[i] ? 84 : 28);
    end
    hold(1'b0, 28);
    IRDA_RXD = 1'b1;
    repeat (10) @(negedge clk);
    Rkey = 1'b0;
    #1;
    check_eq("midrst.frame", frame, 32'h0);
    check_eq("midrst.cmd", {24'h0, cmd}, 32'h0);
    repeat (5) @(negedge clk);
    Rkey = 1'b1;
    hold(1'b1, 200);
    check_pulses("midrst_release", 0, 0, 0);
    snap();
    send_repeat();
    check_pulses("midrst_repeat", 0, 0, 0);
    snap();
    send_frame(d_a, -1, 0, 1'b0);
    check_pulses("midrst_next", 1, 0, 0);
    check_eq("midrst_next.frame", frame, 32'hBA45FF00);

    snap();
    send_frame(d_b, 0, 20, 1'b0);
    check_pulses("sp20", 1, 0, 0);
    check_eq("sp20.frame", frame, 32'hED12FB04);
    snap();
    send_frame(d_a, 1, 40, 1'b0);
    check_pulses("sp40", 1, 0, 0);
    check_eq("sp40.frame", frame, 32'hBA45FF00);
    snap();
    send_frame(d_b, 8, 70, 1'b0);
    check_pulses("sp70", 1, 0, 0);
    check_eq("sp70.frame", frame, 32'hED12FB04);
    snap();
    send_frame(d_a, 9, 95, 1'b0);
    check_pulses("sp95", 1, 0, 0);
    check_eq("sp95.frame", frame, 32'hBA45FF00);

    snap();
    send_frame(d_b, 0, 19, 1'b1);
    check_pulses("sp19", 0, 0, 1);
    snap();
    send_frame(d_b, 1, 41, 1'b1);
    check_pulses("sp41", 0, 0, 1);
    snap();
    send_frame(d_b, 8, 69, 1'b1);
    check_pulses("sp69", 0, 0, 1);
    snap();
    send_frame(d_b, 9, 96, 1'b1);
    check_pulses("sp96", 0, 0, 1);
    check_eq("bad_space.frame", frame, 32'hBA45FF00);

    check_eq("pulse_overlap", 32'(c_overlap), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ir_nec_decoder.md
IR_NEC_DECODER -- requirements
Module: ir_nec_decoder

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, system clock frequency used to derive all timing windows.
REQ-002 SHALL have parameter CHECK_ADDR, default 0, 1 = also require byte1 == ~byte0.
REQ-003 SHALL have port clk  input  1  system clock, rising-edge.
REQ-004 SHALL have port Rkey  input  1  asynchronous active-low reset.
REQ-005 SHALL have port IRDA_RXD  input  1  raw IR receiver output, asynchronous, idle high, carrier burst = low.
REQ-006 SHALL have port frame  output  32  last accepted NEC frame, bit0 = first received bit.
REQ-007 SHALL have port cmd  output  8  frame[23:16] of last accepted frame.
REQ-008 SHALL have port valid  output  1  one-cycle pulse on new accepted frame.
REQ-009 SHALL have port rpt  output  1  one-cycle pulse on accepted repeat code.
REQ-010 SHALL have port err  output  1  one-cycle pulse on aborted or rejected frame.

Function
REQ-011 SHALL pass IRDA_RXD through a 2-flop synchronizer and detect rise/fall on the synchronized signal; total input latency 3 clk.
REQ-012 SHALL time each low (mark) and high (space) interval with one saturating counter cleared at every edge, width ceil(log2(10 ms * CLK_HZ)) + 1.
REQ-013 SHALL use windows: lead mark 8.0-10.0 ms; lead space 4.0-5.0 ms; repeat space 2.0-2.5 ms; bit mark 0.4-0.7 ms; data-0 space 0.4-0.8 ms; data-1 space 1.4-1.9 ms (CLK_HZ=50 MHz: 400000-500000, 200000-250000, 100000-125000, 20000-35000, 20000-40000, 70000-95000 clk).
REQ-014 SHALL implement FSM states IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, RPT_STOP.
REQ-015 IDLE -> LEAD_MARK on falling edge; LEAD_MARK -> LEAD_SPACE on rising edge with mark in window, else -> IDLE with err.
REQ-016 LEAD_SPACE on falling edge: lead-space window -> BIT_MARK with bit count 0; repeat window -> RPT_STOP; otherwise -> IDLE with err.
REQ-017 BIT_MARK -> BIT_SPACE on rising edge with bit-mark window, else -> IDLE with err.
REQ-018 BIT_SPACE on falling edge shifts in 0 or 1 per window (LSB first), increments bit count, returns to BIT_MARK; after 32nd bit -> STOP_MARK; space in neither window -> IDLE with err.
REQ-019 STOP_MARK on rising edge with bit-mark window: check byte3 == ~byte2 (and byte1 == ~byte0 if CHECK_ADDR); pass -> update frame/cmd, pulse valid; fail -> frame/cmd held, pulse err; -> IDLE either way.
REQ-020 RPT_STOP on rising edge with bit-mark window: pulse rpt only if a valid frame was accepted since reset, frame/cmd unchanged; else silent; -> IDLE.
REQ-021 SHALL abort to IDLE with err when the timing counter exceeds the upper bound of the current state's window while no edge has arrived (timeout); IDLE itself never times out.
REQ-022 valid, rpt, err SHALL be mutually exclusive and assert the cycle after the deciding edge is seen.
REQ-023 A falling edge arriving while in IDLE after an abort SHALL immediately start a new frame (no dead time).

Reset
REQ-024 Rkey low SHALL asynchronously force state IDLE, counter 0, bit count 0, shift register 0, frame 0, cmd 0, valid/rpt/err 0, repeat-enable 0, synchronizer flops 1.
REQ-025 Reset mid-frame SHALL discard the partial frame with no pulse on any output after release.

Structure
REQ-026 Timing window constants, derived from CLK_HZ, and the FSM state enum SHALL live in shared package ir_nec_pkg.
REQ-027 Synchronizer and edge detection SHALL be sub-module ir_sync_edge (outputs level, rise, fall).
REQ-028 Expected size 150-300 lines RTL; no memories, single clock domain.

Verification
REQ-029 Full frame addr 0x00, cmd 0x45 (bytes 00 FF 45 BA) -> one valid pulse, cmd=0x45, frame=0xBA45FF00.
REQ-030 After REQ-029 send repeat code (9 ms, 2.25 ms, 0.56 ms mark) -> one rpt pulse, frame unchanged; repeat code straight after reset -> no pulse.
REQ-031 Frame with byte3=0xBB (bad complement) -> one err pulse, frame/cmd keep prior values.
REQ-032 Lead mark 7 ms, and separately line held low 12 ms -> err pulse, FSM back in IDLE, following good frame decoded correctly.
REQ-033 Assert Rkey after bit 16 of a frame -> all outputs 0 immediately, no pulse after release, next full frame decoded.
REQ-034 Boundary timing: bit spaces at 20000/40000/70000/95000 clk accepted, 19999/40001/69999/95001 clk -> err.
